// File: rtl/chien_root_detect.sv
// Chien search controller: sequences the per-term cells, sums their outputs into
// Lambda(alpha^k), flags roots as error positions and checks root count vs degree.
module chien_root_detect #(
  parameter int N    = 15,
  parameter int POSW = 4
) (
  input  logic            CLK,
  input  logic            RESET,
  input  logic            START,
  input  logic [1:0]      DEGREE,
  input  logic [3:0]      Chien_0,
  input  logic [3:0]      Chien_1,
  input  logic [3:0]      Chien_2,
  output logic            CONTROL,
  output logic            BUSY,
  output logic            ERR_VALID,
  output logic [POSW-1:0] ERR_POS,
  output logic [POSW-1:0] ROOT_COUNT,
  output logic            DONE,
  output logic            FAIL
);

  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_SEARCH, S_FIN} state_t;

  localparam logic [POSW-1:0] N_P = POSW'(N);

  state_t          state_q, state_d;
  logic [POSW-1:0] k_q, k_d;
  logic [1:0]      degree_q, degree_d;
  logic            err_valid_q, err_valid_d;
  logic [POSW-1:0] err_pos_q, err_pos_d;
  logic [POSW-1:0] root_count_q, root_count_d;
  logic            fail_q, fail_d;
  logic [3:0]      sum;

  assign sum = Chien_0 ^ Chien_1 ^ Chien_2;

  always_comb begin
    state_d      = state_q;
    k_d          = k_q;
    degree_d     = degree_q;
    err_valid_d  = 1'b0;
    err_pos_d    = err_pos_q;
    root_count_d = root_count_q;
    fail_d       = fail_q;
    CONTROL      = 1'b0;
    BUSY         = 1'b0;
    DONE         = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (START) begin
          state_d      = S_LOAD;
          degree_d     = DEGREE;
          root_count_d = '0;
          fail_d       = 1'b0;
        end
      end
      S_LOAD: begin
        CONTROL = 1'b1;
        BUSY    = 1'b1;
        k_d     = POSW'(1);
        state_d = S_SEARCH;
      end
      S_SEARCH: begin
        BUSY = 1'b1;
        k_d  = k_q + POSW'(1);
        // Position index runs opposite to k; ERR_POS only moves on a root.
        if (sum == 4'h0) begin
          err_valid_d  = 1'b1;
          err_pos_d    = (k_q == N_P) ? '0 : N_P - k_q;
          root_count_d = root_count_q + POSW'(1);
        end
        if (k_q == N_P) begin
          state_d = S_FIN;
          fail_d  = (root_count_d != POSW'(degree_q));
        end
      end
      S_FIN: begin
        BUSY    = 1'b1;
        DONE    = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state_q      <= S_IDLE;
      k_q          <= '0;
      degree_q     <= 2'd0;
      err_valid_q  <= 1'b0;
      err_pos_q    <= '0;
      root_count_q <= '0;
      fail_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      k_q          <= k_d;
      degree_q     <= degree_d;
      err_valid_q  <= err_valid_d;
      err_pos_q    <= err_pos_d;
      root_count_q <= root_count_d;
      fail_q       <= fail_d;
    end
  end

  assign ERR_VALID  = err_valid_q;
  assign ERR_POS    = err_pos_q;
  assign ROOT_COUNT = root_count_q;
  assign FAIL       = fail_q;

endmodule

// File: tb/tb_chien_root_detect.sv
// Bench for chien_root_detect: models the three Chien cells, predicts roots by direct
// polynomial evaluation into a queue and checks them as ERR_VALID pulses appear.
module tb_chien_root_detect;

  logic       CLK = 1'b0;
  logic       RESET;
  logic       START;
  logic [1:0] DEGREE;
  logic [3:0] Chien_0, Chien_1, Chien_2;
  logic       CONTROL, BUSY, ERR_VALID, DONE, FAIL;
  logic [3:0] ERR_POS, ROOT_COUNT;

  logic [3:0] g0, g1, g2;
  int total = 0;
  int bad = 0;
  int exp_q[$];

  chien_root_detect #(.N(15), .POSW(4)) dut (
    .CLK(CLK), .RESET(RESET), .START(START), .DEGREE(DEGREE),
    .Chien_0(Chien_0), .Chien_1(Chien_1), .Chien_2(Chien_2),
    .CONTROL(CONTROL), .BUSY(BUSY), .ERR_VALID(ERR_VALID), .ERR_POS(ERR_POS),
    .ROOT_COUNT(ROOT_COUNT), .DONE(DONE), .FAIL(FAIL)
  );

  always #5 CLK = ~CLK;

  function automatic logic [3:0] gf_mul(input logic [3:0] a, input logic [3:0] b);
    logic [3:0] p;
    logic [3:0] x;
    p = 4'h0;
    x = a;
    for (int i = 0; i < 4; i++) begin
      if (b[i]) p = p ^ x;
      x = {x[2:0], 1'b0} ^ (x[3] ? 4'h3 : 4'h0);
    end
    return p;
  endfunction

  // Term cells: load Gamma_i*alpha^i on CONTROL, else multiply by alpha^i each cycle.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      Chien_0 <= 4'h0;
      Chien_1 <= 4'h0;
      Chien_2 <= 4'h0;
    end else if (CONTROL) begin
      Chien_0 <= g0;
      Chien_1 <= gf_mul(g1, 4'h2);
      Chien_2 <= gf_mul(g2, 4'h4);
    end else begin
      Chien_0 <= Chien_0;
      Chien_1 <= gf_mul(Chien_1, 4'h2);
      Chien_2 <= gf_mul(Chien_2, 4'h4);
    end
  end

  task automatic push_expected();
    logic [3:0] a;
    logic [3:0] v;
    a = 4'h1;
    exp_q.delete();
    for (int k = 1; k <= 15; k++) begin
      a = gf_mul(a, 4'h2);
      v = g0 ^ gf_mul(g1, a) ^ gf_mul(g2, gf_mul(a, a));
      if (v == 4'h0) exp_q.push_back((k == 15) ? 0 : 15 - k);
    end
  endtask

  // Returns at the negedge where DONE is visible (16 edges after the accepting edge).
  task automatic run_search(input logic [3:0] a0, input logic [3:0] a1, input logic [3:0] a2,
                            input logic [1:0] deg, input int exp_cnt, input logic exp_fail,
                            input bit poke, input string name);
    int cyc;
    int ctl_cnt;
    int p;
    bit done_seen;
    bit busy_bad;
    g0 = a0; g1 = a1; g2 = a2;
    push_expected();
    @(negedge CLK);
    DEGREE = deg;
    START = 1'b1;
    @(negedge CLK);
    START = 1'b0;
    DEGREE = 2'd3;
    cyc = 0; ctl_cnt = 0; done_seen = 0; busy_bad = 0;
    total++;
    if (ROOT_COUNT !== 4'd0 || FAIL !== 1'b0) begin
      bad++;
      $display("FAIL %s start_clear: got count=%0d fail=%0b, want 0/0", name, ROOT_COUNT, FAIL);
    end
    total++;
    if (CONTROL !== 1'b1) begin
      bad++;
      $display("FAIL %s control_load: got %0b want 1", name, CONTROL);
    end
    while (!done_seen && cyc < 40) begin
      if (CONTROL === 1'b1) ctl_cnt++;
      if (cyc <= 16 && BUSY !== 1'b1) busy_bad = 1;
      if (ERR_VALID === 1'b1) begin
        total++;
        if (exp_q.size() == 0) begin
          bad++;
          $display("FAIL %s extra_root: got pos=%0d at cyc %0d, want none", name, ERR_POS, cyc);
        end else begin
          p = exp_q.pop_front();
          if (ERR_POS !== 4'(p) || cyc != 16 - p) begin
            bad++;
            $display("FAIL %s root_pos: got pos=%0d cyc=%0d, want pos=%0d cyc=%0d",
                     name, ERR_POS, cyc, p, 16 - p);
          end
        end
      end
      if (DONE === 1'b1) begin
        done_seen = 1;
        total++;
        if (cyc != 16 || ROOT_COUNT !== 4'(exp_cnt) || FAIL !== exp_fail) begin
          bad++;
          $display("FAIL %s done: got cyc=%0d count=%0d fail=%0b, want cyc=16 count=%0d fail=%0b",
                   name, cyc, ROOT_COUNT, FAIL, exp_cnt, exp_fail);
        end
      end
      if (poke && cyc == 5) START = 1'b1;
      if (poke && cyc == 6) START = 1'b0;
      if (!done_seen) begin
        @(negedge CLK);
        cyc++;
      end
    end
    total++;
    if (!done_seen) begin
      bad++;
      $display("FAIL %s done_timeout: got no DONE in %0d cycles, want DONE at 16", name, cyc);
    end
    total++;
    if (ctl_cnt != 1) begin
      bad++;
      $display("FAIL %s control_width: got %0d cycles, want 1", name, ctl_cnt);
    end
    total++;
    if (busy_bad) begin
      bad++;
      $display("FAIL %s busy: got low during search, want high cyc 0..16", name);
    end
    total++;
    if (exp_q.size() != 0) begin
      bad++;
      $display("FAIL %s missing_roots: got %0d unreported, want 0", name, exp_q.size());
    end
  endtask

  // One cycle past DONE: idle, results held; optional START during FIN must be ignored.
  task automatic check_idle(input bit poke_fin, input int exp_cnt, input logic exp_fail,
                            input string name);
    START = poke_fin;
    @(negedge CLK);
    START = 1'b0;
    total++;
    if (BUSY !== 1'b0 || DONE !== 1'b0 || ROOT_COUNT !== 4'(exp_cnt) || FAIL !== exp_fail) begin
      bad++;
      $display("FAIL %s idle_hold: got busy=%0b done=%0b count=%0d fail=%0b, want 0 0 %0d %0b",
               name, BUSY, DONE, ROOT_COUNT, FAIL, exp_cnt, exp_fail);
    end
  endtask

  task automatic test_reset();
    RESET = 1'b1; START = 1'b0; DEGREE = 2'd0;
    g0 = 4'h0; g1 = 4'h0; g2 = 4'h0;
    repeat (2) @(negedge CLK);
    total++;
    if ({CONTROL, BUSY, ERR_VALID, ERR_POS, ROOT_COUNT, DONE, FAIL} !== 13'd0) begin
      bad++;
      $display("FAIL reset_values: got %b, want all zero",
               {CONTROL, BUSY, ERR_VALID, ERR_POS, ROOT_COUNT, DONE, FAIL});
    end
    RESET = 1'b0;
    @(negedge CLK);
    DEGREE = 2'd1;
    START = 1'b1;
    @(negedge CLK);
    START = 1'b0;
    repeat (6) @(negedge CLK);
    total++;
    if (ROOT_COUNT === 4'd0 || BUSY !== 1'b1) begin
      bad++;
      $display("FAIL reset_pre: got count=%0d busy=%0b, want count>0 busy=1", ROOT_COUNT, BUSY);
    end
    #2 RESET = 1'b1;
    #1;
    total++;
    if ({CONTROL, BUSY, ERR_VALID, ERR_POS, ROOT_COUNT, DONE, FAIL} !== 13'd0) begin
      bad++;
      $display("FAIL reset_async: got %b, want all zero",
               {CONTROL, BUSY, ERR_VALID, ERR_POS, ROOT_COUNT, DONE, FAIL});
    end
    @(negedge CLK);
    RESET = 1'b0;
    run_search(4'h1, 4'h8, 4'h0, 2'd1, 1, 1'b0, 0, "after_reset");
    check_idle(0, 1, 1'b0, "after_reset");
  endtask

  task automatic test_single_error();
    run_search(4'h1, 4'h8, 4'h0, 2'd1, 1, 1'b0, 0, "single");
    check_idle(0, 1, 1'b0, "single");
  endtask

  task automatic test_two_errors();
    run_search(4'h1, 4'h1, 4'h6, 2'd2, 2, 1'b0, 0, "two");
    check_idle(0, 2, 1'b0, "two");
  endtask

  task automatic test_uncorrectable();
    // 1 + x + alpha^3 x^2 is irreducible over GF(16).
    run_search(4'h1, 4'h1, 4'h8, 2'd2, 0, 1'b1, 0, "uncorr");
    check_idle(0, 0, 1'b1, "uncorr");
  endtask

  task automatic test_degenerate();
    run_search(4'h1, 4'h0, 4'h0, 2'd0, 0, 1'b0, 0, "no_err");
    check_idle(0, 0, 1'b0, "no_err");
    run_search(4'h0, 4'h0, 4'h0, 2'd0, 15, 1'b1, 0, "all_zero");
    check_idle(0, 15, 1'b1, "all_zero");
  endtask

  task automatic test_start_ignored();
    run_search(4'h1, 4'h1, 4'h6, 2'd2, 2, 1'b0, 1, "start_ign");
    check_idle(1, 2, 1'b0, "start_ign");
  endtask

  task automatic test_back_to_back();
    run_search(4'h0, 4'h0, 4'h0, 2'd1, 15, 1'b1, 0, "b2b_first");
    run_search(4'h1, 4'h8, 4'h0, 2'd1, 1, 1'b0, 0, "b2b_second");
    check_idle(0, 1, 1'b0, "b2b_second");
  endtask

  initial begin
    test_reset();
    test_single_error();
    test_two_errors();
    test_uncorrectable();
    test_degenerate();
    test_start_ignored();
    test_back_to_back();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
